// File: rtl/mix_columns_seq.sv
// mix_columns_seq
// Column-serial AES-128 MixColumns stage for the encrypt datapath. One 32-bit
// column of the captured state is transformed per clock by a single shared
// column unit. A bypass flag passes the state straight through for the final
// round.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   inData    128-bit state from ShiftRows; column c = inData[127-32c -: 32],
//             row r of column c = bits [127-32c-8r -: 8]
//   inValid   inData/inBypass are valid
//   inBypass  final round: output equals input
//   inReady   block can accept a state (IDLE only)
//   outData   MixColumns result, same byte mapping as inData
//   outValid  outData is valid (DONE only)
//   outReady  consumer accepts outData
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a state; inReady=1
// BUSY  | transforming column colCnt into result, one per cycle
// DONE  | result presented with outValid=1 until outReady

module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] inData,
  input  logic         inValid,
  input  logic         inBypass,
  output logic         inReady,
  output logic [127:0] outData,
  output logic         outValid,
  input  logic         outReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT        state;
  stateT        nextState;
  logic [1:0]   colCnt;
  logic [127:0] working;
  logic [127:0] result;
  logic [31:0]  colIn;
  logic [31:0]  colOut;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Byte 0 of the column is the most significant byte (row 0).
  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  assign accept  = inValid & inReady;
  assign outData = result;

  // Column selector feeding the shared column unit.
  always_comb begin
    colIn = working[127:96];
    case (colCnt)
      2'd0: colIn = working[127:96];
      2'd1: colIn = working[95:64];
      2'd2: colIn = working[63:32];
      2'd3: colIn = working[31:0];
      default: colIn = working[127:96];
    endcase
  end

  assign colOut = mixColumn(colIn);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = inBypass ? DONE : BUSY;
      BUSY: if (colCnt == 2'd3) nextState = DONE;
      DONE: if (outReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    case (state)
      IDLE:    inReady = 1'b1;
      DONE:    outValid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the captured working copy isolates the block from input
  // changes after accept; result holds its value outside BUSY/accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      working <= '0;
      result  <= '0;
      colCnt  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            working <= inData;
            colCnt  <= 2'd0;
            if (inBypass) result <= inData;
          end
        end
        BUSY: begin
          // Wraps 3 -> 0 on the way into DONE.
          colCnt <= colCnt + 2'd1;
          case (colCnt)
            2'd0: result[127:96] <= colOut;
            2'd1: result[95:64]  <= colOut;
            2'd2: result[63:32]  <= colOut;
            2'd3: result[31:0]   <= colOut;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq
// Self-checking bench for mix_columns_seq. Expected results come from a
// matrix-times-column reference over GF(2^8) using a generic shift-and-add
// multiplier. Inputs are driven and outputs sampled on the falling edge.

module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] inData;
  logic         inValid;
  logic         inBypass;
  logic         inReady;
  logic [127:0] outData;
  logic         outValid;
  logic         outReady;

  int nChecks = 0;
  int nFail   = 0;

  mix_columns_seq dut (
    .clk      (clk),
    .rst      (rst),
    .inData   (inData),
    .inValid  (inValid),
    .inBypass (inBypass),
    .inReady  (inReady),
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady)
  );

  always #5 clk = ~clk;

  // Generic GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input int k);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (((k >> i) & 1) == 1) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] mixRef(input logic [127:0] s, input logic byp);
    int m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gfMul(a[k], m[row][k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction from IDLE. Latency is counted in clock edges after the
  // accepting edge until outValid is seen: 4 normal, 0 bypass. holdCycles
  // keeps outReady low in DONE, with an ignored inValid pulse part-way.
  task automatic runVector(input string tag, input logic [127:0] d, input logic byp,
                           input int holdCycles, output logic [127:0] got);
    int lat;
    logic [127:0] held;
    @(negedge clk);
    check({tag, " inReady idle"}, 128'(inReady), 128'(1'b1));
    inData   = d;
    inBypass = byp;
    inValid  = 1'b1;
    outReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inValid  = 1'b0;
    inData   = rand128();
    inBypass = ~byp;
    lat = 0;
    while (!outValid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), byp ? 128'(0) : 128'(4));
    got = outData;
    check({tag, " data"}, outData, mixRef(d, byp));
    held = outData;
    for (int i = 0; i < holdCycles; i++) begin
      if (i == 5) begin
        inValid = 1'b1;
        inData  = rand128();
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
      check({tag, " hold"}, {outData, outValid, inReady}, {held, 1'b1, 1'b0});
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    check({tag, " after transfer"}, 128'({inReady, outValid}), 128'(2'b10));
    if (holdCycles > 0) begin
      @(negedge clk);
      check({tag, " no second output"}, 128'({inReady, outValid}), 128'(2'b10));
    end
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] vec [3];
    logic [127:0] outs [3];
    int accCyc [3];
    int acc;
    int nOut;
    int cyc;
    logic accepting;
    logic sawValid;

    rst      = 1'b1;
    inData   = '0;
    inValid  = 1'b0;
    inBypass = 1'b0;
    outReady = 1'b0;
    #1;
    check("reset outData", outData, 128'h0);
    check("reset flags", 128'({outValid, inReady}), 128'(2'b01));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    runVector("fips", 128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b0, 0, got);
    check("fips literal", got, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6);

    runVector("bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 0, got);
    check("bypass literal", got, 128'h00112233_44556677_8899aabb_ccddeeff);

    runVector("edges", 128'h80808080_c6c6c6c6_2d26314c_db135345, 1'b0, 0, got);
    check("edges literal", got, 128'h80808080_c6c6c6c6_4d7ebdf8_8e4da1bc);

    runVector("backpressure", rand128(), 1'b0, 10, got);

    // Reset after two BUSY cycles.
    @(negedge clk);
    inData  = rand128();
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midbusy reset outData", outData, 128'h0);
    check("midbusy reset flags", 128'({outValid, inReady}), 128'(2'b01));
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    check("midbusy no output", 128'(sawValid), 128'(1'b0));
    runVector("post reset", 128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b0, 0, got);

    for (int i = 0; i < 6; i++) begin
      runVector("random", rand128(), 1'($urandom_range(0, 1)), 0, got);
    end

    // Back-to-back: inValid held high, outReady high throughout.
    for (int i = 0; i < 3; i++) vec[i] = rand128();
    @(negedge clk);
    inData   = vec[0];
    inBypass = 1'b0;
    inValid  = 1'b1;
    outReady = 1'b1;
    acc  = 0;
    nOut = 0;
    cyc  = 0;
    while ((acc < 3 || nOut < 3) && cyc < 60) begin
      if (outValid && nOut < 3) begin
        outs[nOut] = outData;
        nOut++;
      end
      accepting = inValid && inReady;
      @(posedge clk);
      if (accepting && acc < 3) begin
        accCyc[acc] = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (accepting) begin
        if (acc < 3) inData = vec[acc];
        else inValid = 1'b0;
      end
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    check("b2b completed", 128'({acc, nOut}), 128'({32'd3, 32'd3}));
    if (acc == 3 && nOut == 3) begin
      check("b2b spacing 0-1", 128'(accCyc[1] - accCyc[0]), 128'(6));
      check("b2b spacing 1-2", 128'(accCyc[2] - accCyc[1]), 128'(6));
      for (int i = 0; i < 3; i++) check("b2b data", outs[i], mixRef(vec[i], 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
